hazard_sched_unit: RTL and testbench
====================================

Name: hazard_sched_unit

Overview:
Pipeline hazard and stall scheduler for the 5-stage MIPS core. It sits beside the control unit and datapath and computes forwarding selects, load-use and branch stalls, and flushes. It also sequences data-memory accesses in MEM through a req/ack handshake with wait states and a timeout watchdog. It keeps saturating stall-cycle counters for performance monitoring.

Parameters:
REG_W, 5, register-index width
TIMEOUT, 16, max MEM wait cycles before fault (>=2)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
RsD, RtD  in  REG_W  source regs in ID
RsE, RtE  in  REG_W  source regs in EX
WriteRegE, WriteRegM, WriteRegW  in  REG_W  dest regs in EX/MEM/WB
RegWriteE, RegWriteM, RegWriteW  in  1  write enables per stage
MemtoRegE, MemtoRegM  in  1  load in EX/MEM
MemWriteM  in  1  store in MEM
BranchD  in  1  branch in ID
dmem_ack  in  1  memory access complete (may be combinational from dmem_req)
cnt_clr  in  1  synchronous clear of counters
dmem_req  out  1  memory access request
ForwardAD, ForwardBD  out  1  ID-stage branch-compare forward from MEM
ForwardAE, ForwardBE  out  2  EX operand select
StallF, StallD, StallE, StallM  out  1  stage-register hold
FlushE, FlushW  out  1  bubble insert into ID/EX, MEM/WB
mem_timeout  out  1  sticky fault flag
stall_cnt  out  CNT_W  load-use/branch stall cycles
memwait_cnt  out  CNT_W  memory wait cycles

Behaviour:
Clock and reset are as decided: one clock (clk), reset is asynchronous and active-low (reset_n).
- Reset values: state=M_IDLE, mem_timeout=0, stall_cnt=0, memwait_cnt=0. While reset_n=0, dmem_req=0 and all Stall/Flush outputs are 0.
- Forwarding (combinational): ForwardAE=2'b10 if RsE!=0 & RegWriteM & WriteRegM==RsE. Otherwise 2'b01 if RsE!=0 & RegWriteW & WriteRegW==RsE. Otherwise 2'b00. MEM has priority over WB. ForwardBE uses the same rule with RtE.
- ForwardAD = RsD!=0 & RegWriteM & WriteRegM==RsD. ForwardBD uses the same rule with RtD.
- lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
- branchstall = BranchD & ((RegWriteE & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & (WriteRegM==RsD | WriteRegM==RtD))).
- MemReqM = MemtoRegM | MemWriteM.
- Memory FSM states:
  - M_IDLE: dmem_req=MemReqM. If MemReqM & dmem_ack, stay (zero-wait). If MemReqM & !dmem_ack, go to M_WAIT with wait_cnt=1.
  - M_WAIT: dmem_req=1. On dmem_ack, go to M_IDLE. Else if wait_cnt==TIMEOUT-1, go to M_ERR and set mem_timeout. Else wait_cnt++.
  - M_ERR: dmem_req=0, pipeline frozen. Exit only via reset.
- mem_stall = (MemReqM & !dmem_ack & state!=M_ERR) | state==M_ERR.
- Output priority 1, mem_stall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushE=0. Hazard stalls are suppressed this cycle.
- Output priority 2, lwstall|branchstall: StallF=StallD=1, FlushE=1, others 0.
- Otherwise all Stall/Flush outputs are 0.
- Counters:
  - stall_cnt increments on cycles with priority-2 stall.
  - memwait_cnt increments on cycles with mem_stall & state!=M_ERR.
  - Both saturate at all-ones. cnt_clr has priority over increment.
- Ack arriving on the cycle wait_cnt==TIMEOUT-1 counts as success and goes to M_IDLE, not M_ERR.
- Async reset mid-wait returns to M_IDLE immediately. dmem_req drops in the same cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Memory FSM state enum {M_IDLE, M_WAIT, M_ERR}.
  - REG_W default.
- One sub-module, dmem_wait_fsm, contains the state register, wait_cnt, mem_timeout, dmem_req and mem_stall generation.
- Forwarding, stall and flush logic and the counters stay in the top module.

Test Plan:
- Forwarding: RegWriteM=1, WriteRegM=5, RsE=5, and RegWriteW=1, WriteRegW=5 -> ForwardAE=10 (MEM wins). Repeat with RsE=0 -> 00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 -> StallF=StallD=FlushE=1 for one cycle, stall_cnt=1.
- Branch: BranchD=1, RegWriteE=1, WriteRegE=RtD=3 -> stall. Next cycle MemtoRegM=1, WriteRegM=3 -> stall again, stall_cnt=2.
- Memory 3-wait: MemWriteM=1, ack after 3 cycles -> StallF/D/E/M and FlushW high 3 cycles, dmem_req high 4 cycles, memwait_cnt=3, back to M_IDLE.
- Timeout with TIMEOUT=4: no ack -> mem_timeout=1 after 4th cycle, outputs frozen. Repeat with ack on 4th cycle -> no fault. Pull reset_n low mid-M_WAIT -> all outputs 0, counters 0.
- Saturation and clear: CNT_W=4, 20 stall cycles -> stall_cnt=15. cnt_clr together with a stall cycle -> 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard scheduler: forwarding selects,
// memory-handshake FSM states and the default register-index width.
package pipe_pkg;

  localparam int DEF_REG_W = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic [1:0] {
    M_IDLE,
    M_WAIT,
    M_ERR
  } mem_state_e;

endpackage

// File: rtl/dmem_wait_fsm.sv
// Data-memory req/ack sequencer for the MEM stage: tracks wait states,
// raises a sticky timeout fault and produces the memory stall request.
module dmem_wait_fsm
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mem_req,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic mem_stall,
  output logic mem_wait,
  output logic mem_timeout
);

  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WMAX = WCW'(TIMEOUT - 1);

  mem_state_e     state;
  logic [WCW-1:0] wait_cnt;
  logic           in_err;

  assign in_err = (state == M_ERR);

  // Request and stall are combinational so a zero-wait ack completes in one cycle;
  // gating with reset_n drops them as soon as reset asserts.
  assign dmem_req  = reset_n & (((state == M_IDLE) & mem_req) | (state == M_WAIT));
  assign mem_stall = reset_n & ((mem_req & ~dmem_ack & ~in_err) | in_err);
  assign mem_wait  = mem_stall & ~in_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= M_IDLE;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        M_IDLE: begin
          if (mem_req && !dmem_ack) begin
            state    <= M_WAIT;
            wait_cnt <= WCW'(1);
          end
        end
        M_WAIT: begin
          if (dmem_ack) begin
            state <= M_IDLE;
          end else if (wait_cnt == WMAX) begin
            state       <= M_ERR;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        M_ERR:   state <= M_ERR;
        default: state <= M_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_sched_unit.sv
// Hazard/stall scheduler for the 5-stage core: forwarding selects, load-use and
// branch stalls, MEM wait-state stalls and saturating stall-cycle counters.
module hazard_sched_unit
  import pipe_pkg::*;
#(
  parameter int REG_W   = DEF_REG_W,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             BranchD,
  input  logic             dmem_ack,
  input  logic             cnt_clr,
  output logic             dmem_req,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic             rw_m,
                                         input logic [REG_W-1:0] wr_m,
                                         input logic             rw_w,
                                         input logic [REG_W-1:0] wr_w);
    if ((src != '0) && rw_m && (wr_m == src))      return FWD_MEM;
    else if ((src != '0) && rw_w && (wr_w == src)) return FWD_WB;
    else                                            return FWD_NONE;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic mem_req_m;
  logic lwstall;
  logic branchstall;
  logic mem_stall;
  logic mem_wait;
  logic haz_stall;

  assign ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
  assign ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
  assign ForwardAD = (RsD != '0) & RegWriteM & (WriteRegM == RsD);
  assign ForwardBD = (RtD != '0) & RegWriteM & (WriteRegM == RtD);

  assign lwstall     = MemtoRegE & ((RtE == RsD) | (RtE == RtD));
  assign branchstall = BranchD &
                       ((RegWriteE & ((WriteRegE == RsD) | (WriteRegE == RtD))) |
                        (MemtoRegM & ((WriteRegM == RsD) | (WriteRegM == RtD))));
  assign mem_req_m   = MemtoRegM | MemWriteM;

  dmem_wait_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_fsm (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_req    (mem_req_m),
    .dmem_ack   (dmem_ack),
    .dmem_req   (dmem_req),
    .mem_stall  (mem_stall),
    .mem_wait   (mem_wait),
    .mem_timeout(mem_timeout)
  );

  // A memory stall freezes the whole pipe and hides any ID/EX hazard this cycle.
  assign haz_stall = reset_n & ~mem_stall & (lwstall | branchstall);

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (haz_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt   <= '0;
      memwait_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (haz_stall) stall_cnt   <= sat_inc(stall_cnt);
      if (mem_wait)  memwait_cnt <= sat_inc(memwait_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_sched_unit.sv
// Bench for hazard_sched_unit: vector table through a scoreboard queue, then
// hand-written multi-cycle sequences for memory waits, timeout, saturation and reset.
module tb_hazard_sched_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM;
  logic       BranchD, dmem_ack, cnt_clr;
  logic       dmem_req, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushE, FlushW, mem_timeout;
  logic [3:0] stall_cnt, memwait_cnt;

  int checks = 0;
  int errors = 0;

  hazard_sched_unit #(.REG_W(5), .TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .BranchD(BranchD), .dmem_ack(dmem_ack), .cnt_clr(cnt_clr),
    .dmem_req(dmem_req), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushE(FlushE), .FlushW(FlushW), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .memwait_cnt(memwait_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic [7:0] ctl;   // {RegWriteE,RegWriteM,RegWriteW,MemtoRegE,MemtoRegM,MemWriteM,BranchD,dmem_ack}
    logic [12:0] ex;   // {ForwardAE,ForwardBE,ForwardAD,ForwardBD,dmem_req,StallF,StallD,StallE,StallM,FlushE,FlushW}
  } vec_t;

  localparam logic [5:0] ST_NONE = 6'b000000;
  localparam logic [5:0] ST_HAZ  = 6'b110010;
  localparam logic [5:0] ST_MEM  = 6'b111101;

  vec_t vecs[$];
  logic [12:0] exp_q[$];

  function automatic vec_t mk(input logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw,
                              input logic [7:0] ctl, input logic [12:0] ex);
    vec_t v;
    v.rsd = rsd; v.rtd = rtd; v.rse = rse; v.rte = rte;
    v.wre = wre; v.wrm = wrm; v.wrw = wrw; v.ctl = ctl; v.ex = ex;
    return v;
  endfunction

  function automatic logic [5:0] stl_now();
    return {StallF, StallD, StallE, StallM, FlushE, FlushW};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic idle();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM, BranchD, dmem_ack} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counters();
    step();
    idle();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  task automatic load_use();
    idle();
    MemtoRegE = 1'b1; RtE = 5'd8; RsD = 5'd8;
  endtask

  initial begin
    logic [12:0] e;
    vec_t v;

    // Reset state, with inputs that would otherwise request memory and stall
    reset_n = 1'b0;
    cnt_clr = 1'b0;
    idle();
    MemWriteM = 1'b1; MemtoRegE = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_stl", stl_now(), ST_NONE);
    chk("rst_tmo", mem_timeout, 0);
    chk("rst_cnt", {stall_cnt, memwait_cnt}, 0);
    idle();
    reset_n = 1'b1;

    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'b0000_0000, {4'b0000, 3'b000, ST_NONE}));
    vecs.push_back(mk(0, 0, 5, 0, 0, 5, 5, 8'b0110_0000, {4'b1000, 3'b000, ST_NONE}));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5, 5, 8'b0110_0000, {4'b0000, 3'b000, ST_NONE}));
    vecs.push_back(mk(0, 0, 7, 7, 0, 6, 7, 8'b0110_0000, {4'b0101, 3'b000, ST_NONE}));
    vecs.push_back(mk(0, 0, 0, 6, 0, 6, 6, 8'b0110_0000, {4'b0010, 3'b000, ST_NONE}));
    vecs.push_back(mk(9, 9, 0, 0, 0, 9, 0, 8'b0100_0000, {4'b0000, 3'b110, ST_NONE}));
    vecs.push_back(mk(9, 9, 0, 0, 0, 9, 0, 8'b0000_0000, {4'b0000, 3'b000, ST_NONE}));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'b0100_0000, {4'b0000, 3'b000, ST_NONE}));
    vecs.push_back(mk(8, 0, 0, 8, 0, 0, 0, 8'b0001_0000, {4'b0000, 3'b000, ST_HAZ}));
    vecs.push_back(mk(1, 4, 0, 4, 0, 0, 0, 8'b0001_0000, {4'b0000, 3'b000, ST_HAZ}));
    vecs.push_back(mk(1, 2, 0, 4, 0, 0, 0, 8'b0001_0000, {4'b0000, 3'b000, ST_NONE}));
    vecs.push_back(mk(0, 3, 0, 0, 3, 0, 0, 8'b1000_0010, {4'b0000, 3'b000, ST_HAZ}));
    vecs.push_back(mk(0, 3, 0, 0, 0, 3, 0, 8'b0000_1011, {4'b0000, 3'b001, ST_HAZ}));
    vecs.push_back(mk(0, 3, 0, 0, 3, 3, 0, 8'b0000_0010, {4'b0000, 3'b000, ST_NONE}));

    for (int i = 0; i < vecs.size(); i++) begin
      step();
      v = vecs[i];
      RsD = v.rsd; RtD = v.rtd; RsE = v.rse; RtE = v.rte;
      WriteRegE = v.wre; WriteRegM = v.wrm; WriteRegW = v.wrw;
      {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM, BranchD, dmem_ack} = v.ctl;
      exp_q.push_back(v.ex);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_fwdE", i), {ForwardAE, ForwardBE}, e[12:9]);
      chk($sformatf("vec%0d_fwdD", i), {ForwardAD, ForwardBD}, e[8:7]);
      chk($sformatf("vec%0d_req", i), dmem_req, e[6]);
      chk($sformatf("vec%0d_stl", i), stl_now(), e[5:0]);
    end
    step();
    idle();
    chk("tbl_stall_cnt", stall_cnt, 4);
    chk("tbl_memwait_cnt", memwait_cnt, 0);

    // Load-use: exactly one counted stall cycle
    clr_counters();
    load_use();
    step();
    idle();
    chk("lu_stall_cnt", stall_cnt, 1);

    // Branch hazard from EX, then from a load in MEM (zero-wait ack)
    clr_counters();
    BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd3; RtD = 5'd3;
    #1 chk("br_ex_stl", stl_now(), ST_HAZ);
    step();
    idle();
    BranchD = 1'b1; RtD = 5'd3; MemtoRegM = 1'b1; WriteRegM = 5'd3; dmem_ack = 1'b1;
    #1 chk("br_mem_stl", stl_now(), ST_HAZ);
    step();
    idle();
    chk("br_stall_cnt", stall_cnt, 2);

    // Store with ack on the 4th cycle: also the wait_cnt==TIMEOUT-1 boundary
    clr_counters();
    MemWriteM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1;
      chk($sformatf("w3_req%0d", i), dmem_req, 1);
      chk($sformatf("w3_stl%0d", i), stl_now(), (i < 3) ? ST_MEM : ST_NONE);
      step();
    end
    idle();
    #1;
    chk("w3_req_after", dmem_req, 0);
    chk("w3_memwait_cnt", memwait_cnt, 3);
    chk("w3_no_fault", mem_timeout, 0);

    // Memory stall suppresses a simultaneous load-use hazard
    clr_counters();
    load_use();
    MemWriteM = 1'b1;
    #1 chk("pri_mem_stl", stl_now(), ST_MEM);
    step();
    dmem_ack = 1'b1;
    #1 chk("pri_haz_stl", stl_now(), ST_HAZ);
    step();
    idle();
    chk("pri_stall_cnt", stall_cnt, 1);
    chk("pri_memwait_cnt", memwait_cnt, 1);

    // Saturation and clear-over-increment
    clr_counters();
    load_use();
    repeat (20) step();
    chk("sat_stall_cnt", stall_cnt, 15);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_over_inc", stall_cnt, 0);

    // Timeout: four unacknowledged cycles then a frozen pipe
    clr_counters();
    MemWriteM = 1'b1;
    repeat (4) step();
    chk("tmo_flag", mem_timeout, 1);
    chk("tmo_req", dmem_req, 0);
    chk("tmo_stl", stl_now(), ST_MEM);
    chk("tmo_memwait_cnt", memwait_cnt, 4);
    dmem_ack = 1'b1;
    repeat (3) step();
    chk("tmo_sticky", mem_timeout, 1);
    chk("tmo_frozen", stl_now(), ST_MEM);
    chk("tmo_memwait_hold", memwait_cnt, 4);

    // Reset to leave the fault, then asynchronous reset in the middle of a wait
    reset_n = 1'b0;
    idle();
    step();
    reset_n = 1'b1;
    MemWriteM = 1'b1;
    repeat (2) step();
    chk("mid_req_pre", dmem_req, 1);
    chk("mid_memwait_pre", memwait_cnt, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_req", dmem_req, 0);
    chk("mid_stl", stl_now(), ST_NONE);
    chk("mid_cnt", {stall_cnt, memwait_cnt}, 0);
    chk("mid_tmo", mem_timeout, 0);
    step();
    reset_n = 1'b1;
    dmem_ack = 1'b1;
    #1;
    chk("post_rst_idle_req", dmem_req, 1);
    chk("post_rst_idle_stl", stl_now(), ST_NONE);
    step();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
